// File: rtl/mem_read_responder.sv
// Memory-side responder for the CPU read handshake: a word-addressed 16-bit RAM with a side write port.
// Optional address range checking (read_mem_err, dropped out-of-range writes) is enabled by MEM_RESP_RANGE_CHECK_EN.
module mem_read_responder #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_mem_req,
    input  logic [15:0] read_mem_addr,
    output logic        read_mem_valid,
    output logic        read_mem_finish,
    output logic [15:0] out_mem_data,
`ifdef MEM_RESP_RANGE_CHECK_EN
    output logic        read_mem_err,
`endif
    input  logic        mem_we,
    input  logic [15:0] mem_waddr,
    input  logic [15:0] mem_wdata,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] VALID  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [15:0] mem [DEPTH];
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        armed;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        rd_ok;
    logic        wr_ok;

    // DEPTH is a power of two, so the modulo reduces to keeping the low address bits.
    function automatic logic [AW-1:0] word_index(input logic [15:0] a);
        return AW'(32'(a) % 32'(DEPTH));
    endfunction

`ifdef MEM_RESP_RANGE_CHECK_EN
    logic err_q;

    assign rd_ok = 32'(addr_q) < 32'(DEPTH);
    assign wr_ok = 32'(mem_waddr) < 32'(DEPTH);
    assign read_mem_err = rst_n && err_q && (state == VALID || state == FINISH);
`else
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (mem_we && wr_ok) begin
            mem[word_index(mem_waddr)] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            armed  <= 1'b1;
            data_q <= 16'h0000;
`ifdef MEM_RESP_RANGE_CHECK_EN
            err_q  <= 1'b0;
`endif
        end else begin
            // A held request is served once; it must be seen low before the next one is taken.
            if (!read_mem_req) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (read_mem_req && armed) begin
                        addr_q <= read_mem_addr;
                        cnt    <= 4'(READ_LATENCY - 1);
                        armed  <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Non-blocking RAM update makes a same-edge write invisible here.
                        data_q <= rd_ok ? mem[word_index(addr_q)] : 16'h0000;
`ifdef MEM_RESP_RANGE_CHECK_EN
                        err_q  <= !rd_ok;
`endif
                        state  <= VALID;
                    end
                end
                VALID:  state <= FINISH;
                FINISH: state <= IDLE;
            endcase
        end
    end

    assign read_mem_valid  = rst_n && (state == VALID);
    assign read_mem_finish = rst_n && (state == FINISH);
    assign out_mem_data    = rst_n ? data_q : 16'h0000;
    assign busy            = rst_n && (state != IDLE);

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: handshake timing, re-arm, write collision, reset abort, wrap and latency sweep.
module tb_mem_read_responder;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic [15:0] waddr;
    logic [15:0] wdata;

    logic        valid, finish, busy;
    logic [15:0] data;
    logic        valid_1, finish_1, busy_1;
    logic [15:0] data_1;
    logic        valid_15, finish_15, busy_15;
    logic [15:0] data_15;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic        err, err_1, err_15;
`endif

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_read_responder #(.DEPTH(256), .READ_LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .read_mem_req(req), .read_mem_addr(addr),
        .read_mem_valid(valid), .read_mem_finish(finish), .out_mem_data(data),
`ifdef MEM_RESP_RANGE_CHECK_EN
        .read_mem_err(err),
`endif
        .mem_we(we), .mem_waddr(waddr), .mem_wdata(wdata), .busy(busy)
    );

    mem_read_responder #(.DEPTH(256), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .read_mem_req(req), .read_mem_addr(addr),
        .read_mem_valid(valid_1), .read_mem_finish(finish_1), .out_mem_data(data_1),
`ifdef MEM_RESP_RANGE_CHECK_EN
        .read_mem_err(err_1),
`endif
        .mem_we(we), .mem_waddr(waddr), .mem_wdata(wdata), .busy(busy_1)
    );

    mem_read_responder #(.DEPTH(256), .READ_LATENCY(15)) u_l15 (
        .clk(clk), .rst_n(rst_n), .read_mem_req(req), .read_mem_addr(addr),
        .read_mem_valid(valid_15), .read_mem_finish(finish_15), .out_mem_data(data_15),
`ifdef MEM_RESP_RANGE_CHECK_EN
        .read_mem_err(err_15),
`endif
        .mem_we(we), .mem_waddr(waddr), .mem_wdata(wdata), .busy(busy_15)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    // Full read on the latency-2 instance, dropping req on valid.
    task automatic run_read(input string tag, input logic [15:0] a,
                            input logic [15:0] exp, input logic exp_err);
        int n;
        n = 0;
        req = 1'b1; addr = a;
        step();
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        while (!valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, " latency"}, n, 2);
        chk({tag, " data_on_valid"}, 32'(data), 32'(exp));
`ifdef MEM_RESP_RANGE_CHECK_EN
        chk({tag, " err_on_valid"}, 32'(err), 32'(exp_err));
`else
        if (exp_err) $display("note: %s expects err only with range check", tag);
`endif
        req = 1'b0;
        step();
        chk({tag, " finish"}, 32'(finish), 32'd1);
        chk({tag, " valid_dropped"}, 32'(valid), 32'd0);
        chk({tag, " data_on_finish"}, 32'(data), 32'(exp));
`ifdef MEM_RESP_RANGE_CHECK_EN
        chk({tag, " err_on_finish"}, 32'(err), 32'(exp_err));
`endif
        step();
        chk({tag, " idle"}, 32'(busy), 32'd0);
        chk({tag, " finish_dropped"}, 32'(finish), 32'd0);
    endtask

    initial begin
        int nv, nf, n1, n2, n15;
        rst_n = 1'b0; req = 1'b0; addr = 16'h0; we = 1'b0; waddr = 16'h0; wdata = 16'h0;
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset finish", 32'(finish), 32'd0);
        chk("reset data", 32'(data), 32'd0);
        rst_n = 1'b1;

        write_word(16'h0005, 16'hBEEF);
        write_word(16'h0003, 16'h1234);
        write_word(16'h0007, 16'h1111);
        write_word(16'h0010, 16'hCAFE);

        // Basic read with explicit cycle-by-cycle expectations.
        req = 1'b1; addr = 16'h0005;
        step();
        chk("basic E busy", 32'(busy), 32'd1);
        chk("basic E valid", 32'(valid), 32'd0);
        step();
        chk("basic E+1 valid", 32'(valid), 32'd0);
        step();
        chk("basic E+2 valid", 32'(valid), 32'd1);
        chk("basic E+2 data", 32'(data), 32'hBEEF);
        chk("basic E+2 finish", 32'(finish), 32'd0);
        req = 1'b0; addr = 16'h0003;
        step();
        chk("basic E+3 finish", 32'(finish), 32'd1);
        chk("basic E+3 valid", 32'(valid), 32'd0);
        chk("basic E+3 data", 32'(data), 32'hBEEF);
        step();
        chk("basic E+4 busy", 32'(busy), 32'd0);
        chk("basic E+4 data_holds", 32'(data), 32'hBEEF);

        // Held request: served exactly once.
        nv = 0; nf = 0;
        req = 1'b1; addr = 16'h0003;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid) nv++;
            if (finish) nf++;
        end
        chk("held valid_count", nv, 1);
        chk("held finish_count", nf, 1);
        chk("held data", 32'(data), 32'h1234);
        req = 1'b0;
        step();
        req = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid) nv++;
        end
        chk("rearm valid_count", nv, 1);
        req = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Write to the captured address on the capture edge returns the old word.
        req = 1'b1; addr = 16'h0007;
        step();
        step();
        we = 1'b1; waddr = 16'h0007; wdata = 16'h2222;
        step();
        we = 1'b0;
        chk("collision valid", 32'(valid), 32'd1);
        chk("collision old_data", 32'(data), 32'h1111);
        req = 1'b0;
        step();
        step();
        run_read("collision_reread", 16'h0007, 16'h2222, 1'b0);

        // Reset during WAIT aborts the read silently.
        req = 1'b1; addr = 16'h0005;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort valid", 32'(valid), 32'd0);
        chk("abort data", 32'(data), 32'd0);
        rst_n = 1'b1; req = 1'b0;
        nv = 0; nf = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid) nv++;
            if (finish) nf++;
        end
        chk("abort no_valid", nv, 0);
        chk("abort no_finish", nf, 0);
        chk("abort data_still_zero", 32'(data), 32'd0);
        run_read("after_abort", 16'h0005, 16'hBEEF, 1'b0);

        // Address above DEPTH.
`ifdef MEM_RESP_RANGE_CHECK_EN
        run_read("range", 16'h0110, 16'h0000, 1'b1);
        write_word(16'h0110, 16'h5555);
        run_read("range_write_dropped", 16'h0010, 16'hCAFE, 1'b0);
`else
        run_read("wrap", 16'h0110, 16'hCAFE, 1'b0);
        write_word(16'h0105, 16'h7777);
        run_read("wrap_write", 16'h0005, 16'h7777, 1'b0);
`endif

        // Latency sweep across the three instances, all accepting at the same edge.
        for (int i = 0; i < 20; i++) step();
        chk("sweep idle_l1", 32'(busy_1), 32'd0);
        chk("sweep idle_l15", 32'(busy_15), 32'd0);
        n1 = 0; n2 = 0; n15 = 0;
        req = 1'b1; addr = 16'h0003;
        step();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (valid_1 && n1 == 0) n1 = i;
            if (valid && n2 == 0) n2 = i;
            if (valid_15 && n15 == 0) begin
                n15 = i;
                chk("sweep l15 data", 32'(data_15), 32'h1234);
            end
        end
        req = 1'b0;
        chk("sweep latency_1", n1, 1);
        chk("sweep latency_2", n2, 2);
        chk("sweep latency_15", n15, 15);
        chk("sweep l1 data", 32'(data_1), 32'h1234);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
- Memory-side responder for the CPU read handshake (read_mem_req / read_mem_valid / read_mem_finish / in_mem_data).
- Holds a word-addressed 16-bit RAM. Serves one read per request after a fixed wait-state latency, then returns data with a one-cycle valid pulse followed by a one-cycle finish pulse.
- A side write port preloads and updates the RAM (program loader, store path).

Parameters:
- DEPTH, 256, number of 16-bit words; must be a power of two, at most 65536.
- READ_LATENCY, 2, cycles from request acceptance to valid; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- read_mem_req  input  1  read request level from initiator
- read_mem_addr  input  16  word address, sampled at acceptance
- read_mem_valid  output  1  one-cycle pulse; out_mem_data is valid in this cycle
- read_mem_finish  output  1  one-cycle pulse, cycle after valid
- out_mem_data  output  16  read data; connects to initiator in_mem_data
- mem_we  input  1  write enable
- mem_waddr  input  16  write word address
- mem_wdata  input  16  write data
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset:
  - All state changes on posedge clk.
  - rst_n is sampled only at posedge; no async path.
  - While rst_n=0: state=IDLE, cnt=0, armed=1, data register=0. Outputs read_mem_valid=0, read_mem_finish=0, out_mem_data=0, busy=0.
  - RAM contents are not reset.
- States: IDLE, WAIT, VALID, FINISH (2-bit encoding).
- IDLE -> WAIT: when read_mem_req=1 and armed=1. Latch address, load cnt=READ_LATENCY-1, clear armed.
- WAIT:
  - cnt!=0: decrement cnt.
  - cnt==0: capture RAM[latched addr] into the data register and go to VALID.
- VALID: read_mem_valid=1; out_mem_data=data register. Next state is FINISH unconditionally.
- FINISH: read_mem_finish=1; out_mem_data holds the same data. Next state is IDLE.
- Timing: if request is accepted at edge E, valid is high in the cycle after edge E+READ_LATENCY and finish in the cycle after edge E+READ_LATENCY+1. The initiator sees LOADED in the following cycle.
- out_mem_data in IDLE/WAIT: holds the last returned word (0 after reset).
- Re-arm rule:
  - armed is set when read_mem_req is sampled 0 in any state.
  - A request held high through completion is not re-served; the initiator must drop req (it does so on valid) before a new read is accepted.
- Request changes after acceptance: read_mem_req and read_mem_addr changes during WAIT/VALID/FINISH are ignored for the current transaction.
- Address mapping: index = addr mod DEPTH (low log2(DEPTH) bits), unless the optional feature is enabled.
- Write port:
  - mem_we=1 writes mem_wdata to RAM[mem_waddr mod DEPTH] at the edge, in any state.
  - If a write and the WAIT->VALID capture hit the same address at the same edge, the capture returns the OLD word (read-before-write).
  - A write at any earlier edge is visible to the capture.
- Reset mid-transaction: return to IDLE on the reset edge. No valid or finish is emitted for the aborted read. armed=1.

Optional Feature:
- Macro: MEM_RESP_RANGE_CHECK_EN.
- Enabled:
  - Adds output read_mem_err (1 bit, reset 0).
  - If the latched address is >= DEPTH, the captured data is 16'h0000 and read_mem_err=1 during both the VALID and FINISH cycles. Handshake timing is unchanged.
  - Writes with mem_waddr >= DEPTH are dropped.
- Disabled: the port is absent; addresses wrap modulo DEPTH for both reads and writes.

Test Plan:
- Basic read: preload RAM[5]=16'hBEEF, READ_LATENCY=2; raise req with addr=5 at edge E, drop it on valid -> valid only in the cycle after E+2 with data 16'hBEEF; finish only in the cycle after E+3; busy=0 after E+4.
- Held request: keep req=1 for 20 cycles with addr=3 -> exactly one valid/finish pair. Drop req for one cycle and raise it again -> second read served.
- Write collision: RAM[7]=16'h1111; read addr 7; assert mem_we with addr 7, data 16'h2222 on the capture edge -> returns 16'h1111. Next read of addr 7 returns 16'h2222.
- Reset abort: assert rst_n=0 for one cycle during WAIT -> no valid or finish pulse; busy=0, out_mem_data=0. Next request is served normally.
- Wrap/range: DEPTH=256, write 16'hCAFE to addr 16'h0010; read addr 16'h0110 -> without the macro returns 16'hCAFE; with MEM_RESP_RANGE_CHECK_EN returns 16'h0000 and read_mem_err=1 in the valid and finish cycles.
- Latency sweep: READ_LATENCY=1 and 15 -> valid exactly 1 / 15 edges after acceptance.
